// File: rtl/master_req_queue_if.sv
// Requester-side and crossbar-side channels of the master request queue.
// The queue is the slave on the requester channel and the master on the crossbar channel.
interface mrq_req_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_addr;
    logic          in_cmd;
    logic [DW-1:0] in_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;

    modport master (
        output in_valid, in_addr, in_cmd, in_wdata,
        input  in_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  in_valid, in_addr, in_cmd, in_wdata,
        output in_ready, resp_valid, resp_rdata
    );
endinterface

interface mrq_bus_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m_req;
    logic [AW-1:0] m_addr;
    logic          m_cmd;
    logic [DW-1:0] m_wdata;
    logic          m_ack;
    logic [DW-1:0] m_rdata;

    modport master (
        output m_req, m_addr, m_cmd, m_wdata,
        input  m_ack, m_rdata
    );

    modport slave (
        input  m_req, m_addr, m_cmd, m_wdata,
        output m_ack, m_rdata
    );
endinterface

// File: rtl/master_req_queue.sv
// Request queue feeding one crossbar master port; returns read data as a one-cycle pulse.
// Define MRQ_TIMEOUT_EN to drop a head request that waits more than TIMEOUT cycles for ack.
module master_req_queue #(
    parameter int DEPTH   = 4,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic      clk_i,
    input  logic      rst_i,
    mrq_req_if.slave  req,
    mrq_bus_if.master bus
`ifdef MRQ_TIMEOUT_EN
    ,
    output logic      err_timeout_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          cmd;
        logic [DW-1:0] wdata;
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          rd_pend_q, rd_pend_d;
    logic          resp_valid_q, resp_valid_d;
    logic [DW-1:0] resp_rdata_q, resp_rdata_d;

    logic   full, empty, push, ack_pop, tmo_pop, pop;
    entry_t head;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push    = req.in_valid && !full;
    assign ack_pop = !empty && bus.m_ack;
    assign pop     = ack_pop || tmo_pop;
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    assign req.in_ready   = !full;
    assign req.resp_valid = resp_valid_q;
    assign req.resp_rdata = resp_rdata_q;

    assign bus.m_req   = !empty;
    assign bus.m_addr  = head.addr;
    assign bus.m_cmd   = head.cmd;
    assign bus.m_wdata = head.wdata;

`ifdef MRQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          err_q, err_d;

    // An ack in the limit cycle wins, so the drop needs m_ack low.
    assign tmo_pop       = !empty && !bus.m_ack && (tmo_cnt_q == TW'(TIMEOUT));
    assign err_timeout_o = err_q;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        err_d     = tmo_pop;
        if (empty || pop) begin
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end
`else
    logic unused_timeout;

    assign tmo_pop        = 1'b0;
    assign unused_timeout = (TIMEOUT != 0);
`endif

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        resp_rdata_d = resp_rdata_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Only an acked read earns a response; a timed-out head is dropped silently.
        rd_pend_d    = ack_pop && !head.cmd;
        resp_valid_d = rd_pend_q;
        if (rd_pend_q) begin
            resp_rdata_d = bus.m_rdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rd_pend_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rd_pend_q    <= rd_pend_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Storage is not reset; the pointers and count alone define validity.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{addr: req.in_addr, cmd: req.in_cmd, wdata: req.in_wdata};
        end
    end

endmodule

// File: tb/tb_master_req_queue.sv
// Randomized scoreboard bench for master_req_queue against a transaction-level queue model.
module tb_master_req_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
`ifdef MRQ_TIMEOUT_EN
    localparam int TIMEOUT = 8;
`else
    localparam int TIMEOUT = 255;
`endif

    typedef struct {
        logic [AW-1:0] addr;
        logic          cmd;
        logic [DW-1:0] wdata;
    } txn_t;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mrq_req_if #(.AW(AW), .DW(DW)) rq ();
    mrq_bus_if #(.AW(AW), .DW(DW)) bq ();

`ifdef MRQ_TIMEOUT_EN
    logic err_timeout;
`endif

    master_req_queue #(
        .DEPTH(DEPTH), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .req(rq),
        .bus(bq)
`ifdef MRQ_TIMEOUT_EN
        ,
        .err_timeout_o(err_timeout)
`endif
    );

    always #5 clk = ~clk;

    txn_t model[$];
    rsp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    logic pend   = 1'b0;
    logic err_exp = 1'b0;
    int   tcnt   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle: check outputs against the model, drive inputs, advance the model.
    task automatic step(input logic r, input logic v, input logic [AW-1:0] a, input logic c,
                        input logic [DW-1:0] d, input logic ack, input logic [DW-1:0] rd);
        bit do_push, do_pop, tmo;
        txn_t t;
        @(negedge clk);
        cyc++;
        chk("in_ready", rq.in_ready, 64'(model.size() != DEPTH));
        chk("m_req", bq.m_req, 64'(model.size() != 0));
        if (model.size() != 0) begin
            chk("m_addr", bq.m_addr, model[0].addr);
            chk("m_cmd", bq.m_cmd, model[0].cmd);
            chk("m_wdata", bq.m_wdata, model[0].wdata);
        end else begin
            chk("m_idle_bus", {bq.m_addr, bq.m_cmd, bq.m_wdata[30:0]}, 64'd0);
        end
`ifdef MRQ_TIMEOUT_EN
        chk("err_timeout", err_timeout, err_exp);
`endif
        rst         = r;
        rq.in_valid = v;
        rq.in_addr  = a;
        rq.in_cmd   = c;
        rq.in_wdata = d;
        bq.m_ack    = ack;
        bq.m_rdata  = rd;

        if (pend && !r) sb.push_back('{data: rd, cyc: cyc});
        pend    = 1'b0;
        err_exp = 1'b0;
        tmo     = 1'b0;
        if (r) begin
            model.delete();
            tcnt = 0;
        end else begin
            do_pop  = (model.size() != 0) && ack;
            do_push = v && (model.size() != DEPTH);
`ifdef MRQ_TIMEOUT_EN
            if (model.size() != 0 && !ack) begin
                if (tcnt == TIMEOUT) begin
                    tmo  = 1'b1;
                    tcnt = 0;
                end else begin
                    tcnt++;
                end
            end else begin
                tcnt = 0;
            end
`endif
            err_exp = tmo;
            if (do_pop) pend = (model[0].cmd == 1'b0);
            if (do_pop || tmo) void'(model.pop_front());
            if (do_push) begin
                t = '{addr: a, cmd: c, wdata: d};
                model.push_back(t);
            end
        end
    endtask

    task automatic idle(input int n, input logic ack);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0, ack, $urandom);
    endtask

    // Response monitor: samples just after each rising edge.
    initial begin
        rsp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (rq.resp_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_spurious: got resp_valid=1 rdata %0h expected none (cycle %0d)",
                             rq.resp_rdata, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("resp_cycle", 64'(cyc), 64'(e.cyc));
                    chk("resp_rdata", rq.resp_rdata, e.data);
                end
            end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                checks++;
                errors++;
                $display("FAIL resp_missing: got resp_valid=0 expected rdata %0h (cycle %0d)",
                         sb[0].data, cyc);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        rq.in_valid = 1'b0;
        rq.in_addr  = '0;
        rq.in_cmd   = 1'b0;
        rq.in_wdata = '0;
        bq.m_ack    = 1'b0;
        bq.m_rdata  = '0;

        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0);
        @(posedge clk);
        #1;
        chk("rst_resp_rdata", rq.resp_rdata, 64'd0);
        chk("rst_resp_valid", rq.resp_valid, 64'd0);

        // Reset with reads queued, one read response outstanding and ack high.
        step(1'b0, 1'b1, 32'h1000_0000, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b1, 32'h1000_0004, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b1, 32'h1000_0008, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 32'hAAAA_0001);
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, 32'hAAAA_0002);
        idle(3, 1'b1);

        // Write held stable through a 5-cycle stall.
        step(1'b0, 1'b1, 32'h4000_0010, 1'b1, 32'hDEAD_BEEF, 1'b0, '0);
        idle(5, 1'b0);
        idle(3, 1'b1);

        // Read response timing.
        step(1'b0, 1'b1, 32'h8000_0004, 1'b0, 32'h0, 1'b0, '0);
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, 32'h0BAD_0BAD);
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 32'h1234_5678);
        idle(3, 1'b0);

        // Fill, then offer a push while full with a simultaneous ack.
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 1'b1, 32'h2000_0000 + 32'(i * 4), 1'(i & 1), $urandom, 1'b0, '0);
        step(1'b0, 1'b1, 32'h2FFF_FFF0, 1'b1, 32'h5555_5555, 1'b1, $urandom);
        idle(DEPTH + 1, 1'b1);

        // Streaming with ack held high across pointer wrap.
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b1, $urandom, 1'($urandom_range(0, 1)), $urandom, 1'b1, $urandom);
        idle(4, 1'b1);

`ifdef MRQ_TIMEOUT_EN
        step(1'b0, 1'b1, 32'h9000_0000, 1'b0, '0, 1'b0, '0);
        step(1'b0, 1'b1, 32'h9000_0004, 1'b1, 32'h7777_7777, 1'b0, '0);
        idle(TIMEOUT + 4, 1'b0);
        idle(4, 1'b1);
`endif

        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 63) == 0),
                 1'($urandom_range(0, 9) < 6),
                 $urandom, 1'($urandom_range(0, 1)), $urandom,
                 1'($urandom_range(0, 9) < 6), $urandom);
        end

        idle(DEPTH + 4, 1'b1);
        @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/master_req_queue.md
Name: master_req_queue

Overview:
- Master-side request queue that sits directly upstream of one crossbar master port and drives master_N_req/addr/cmd/wdata.
- Buffers up to DEPTH transactions from a local requester.
- Holds each head transaction stable until the crossbar acks it.
- Captures read data on the cycle after ack and returns it as a one-cycle response pulse.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2
- AW, 32, address width
- DW, 32, write/read data width
- TIMEOUT, 255, max cycles the head may wait for ack (used only with MRQ_TIMEOUT_EN)

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  requester offers a transaction
- in_ready  out  1  queue can accept; transfer when in_valid && in_ready
- in_addr  in  AW  transaction address
- in_cmd  in  1  0 = read, 1 = write
- in_wdata  in  DW  write data (don't-care for reads)
- resp_valid  out  1  one-cycle pulse: read data valid
- resp_rdata  out  DW  read data, valid with resp_valid
- m_req  out  1  to crossbar master_N_req
- m_addr  out  AW  to master_N_addr
- m_cmd  out  1  to master_N_cmd
- m_wdata  out  DW  to master_N_wdata
- m_ack  in  1  from master_N_ack
- m_rdata  in  DW  from master_N_rdata; valid the cycle after m_ack for reads
- err_timeout  out  1  one-cycle pulse on a dropped request (present only with MRQ_TIMEOUT_EN)

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-high on rst. In any cycle where rst = 1 at posedge:
  - write/read pointers and count go to 0.
  - rd_pend, resp_valid and err_timeout go to 0; resp_rdata goes to 0.
  - The timeout counter goes to 0.
- Reset mid-transaction:
  - The queue is flushed.
  - m_req is low from the cycle after reset.
  - An outstanding read response is discarded.
  - An ack arriving in the reset cycle is ignored.
- Storage:
  - Circular buffer; pointers are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Push and in_ready:
  - in_ready = (count != DEPTH), taken from registered state only.
  - No pass-through: when full, in_ready stays 0 even if a pop occurs in the same cycle.
  - Push: on in_valid && in_ready, write {addr, cmd, wdata} at wr_ptr and increment wr_ptr.
- Crossbar side:
  - m_req = (count != 0).
  - m_addr/m_cmd/m_wdata are the head entry (rd_ptr).
  - They remain stable while m_req = 1 and m_ack = 0; the head never changes before ack.
  - When the queue is empty, m_addr/m_cmd/m_wdata are driven 0.
- Pop: on m_req && m_ack, increment rd_ptr. The next entry, if any, is presented in the following cycle, so back-to-back transactions with ack held high run at 1 per cycle.
- Count update per cycle:
  - push only: +1
  - pop only: -1
  - push and pop together (possible when not full): unchanged.
  - Push into an empty queue: m_req rises the next cycle; minimum 1-cycle push-to-req latency.
- Read response:
  - On a pop of a read (head cmd = 0), set rd_pend.
  - In the next cycle, register m_rdata into resp_rdata and pulse resp_valid for exactly 1 cycle.
  - resp_valid therefore asserts 2 cycles after the ack cycle edge sequence: ack at cycle T, sample at T+1, resp_valid high during T+2.
  - resp_rdata holds its last value otherwise.
  - There is no backpressure on the response; the requester must accept it.
- Writes: a pop of a write produces no response.
- Responses are returned in issue order. At most one read is outstanding at a time per ack, so consecutive read acks yield consecutive resp_valid pulses.

Optional Feature:
- Macro: MRQ_TIMEOUT_EN.
- Defined:
  - A counter increments each cycle m_req && !m_ack and clears on pop or when the queue is empty.
  - When the counter reaches TIMEOUT with still no ack, the head is popped without response, err_timeout pulses 1 cycle and the counter clears.
  - An ack in the same cycle as the limit wins: normal pop, no error.
- Not defined: no counter and no err_timeout port; the head waits for ack indefinitely.

Test Plan:
1. Reset behaviour: push 3 entries, assert rst 1 cycle -> next cycle m_req = 0, in_ready = 1, count 0, no resp_valid even if m_ack was high.
2. Hold while stalled: push write addr 0x4000_0010 data 0xDEAD_BEEF, hold m_ack = 0 for 5 cycles -> m_req/m_addr/m_wdata stable all 5 cycles; ack -> pop, no resp_valid.
3. Read response timing: push read addr 0x8000_0004, ack at cycle T, m_rdata = 0x1234_5678 at T+1 -> resp_valid = 1 only at T+2 with resp_rdata 0x1234_5678.
4. Full queue: push DEPTH = 4 entries with m_ack = 0 -> in_ready = 0; in_valid with simultaneous ack while full -> not accepted; next cycle in_ready = 1.
5. Streaming with wrap-around: 10 mixed reads/writes, m_ack held 1, push every cycle -> 1 transaction per cycle, order preserved across pointer wrap, reads return data in order.
6. Timeout (MRQ_TIMEOUT_EN, TIMEOUT = 8): push read, never ack -> after 8 stalled cycles err_timeout pulses, head dropped, no resp_valid; the next entry is presented the following cycle.
